ped_signal_ctrl: RTL and testbench

Pedestrian crossing controller that sits directly downstream of the vehicle traffic light. It consumes the vehicle red/yellow/green lamp signals, a raw push-button input, and a 1-second tick from the seconds prescaler. It serves a latched pedestrian request at the start of the next vehicle red phase with WALK, then a flashing CLEAR countdown, then solid DONT_WALK. It aborts to DONT_WALK immediately if vehicle red drops.

---
 rtl/ped_pkg.sv | 7 +
 rtl/ped_signal_ctrl_btn_sync.sv | 13 +
 rtl/ped_signal_ctrl.sv | 108 ++++++++++
 tb/tb_ped_signal_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ped_pkg.sv
// ped_pkg: shared state encoding and default timing for the pedestrian crossing controller
package ped_pkg;
    typedef enum logic [1:0] {DONT_WALK, WALK, CLEAR} ped_state_t;
    localparam int WALK_TIME_DEF  = 7;
    localparam int CLEAR_TIME_DEF = 5;
    localparam int CNT_W_DEF      = 6;
endpackage

// File: rtl/ped_signal_ctrl_btn_sync.sv
// ped_btn_sync: 2-FF synchronizer for the raw push button plus a one-cycle rising-edge pulse
module ped_btn_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise_pulse
);
    logic [2:0] r_sh;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_sh <= '0;
        else        r_sh <= {r_sh[1:0], async_in};
    assign rise_pulse = r_sh[1] & ~r_sh[2];
endmodule

// File: rtl/ped_signal_ctrl.sv
// ped_signal_ctrl: pedestrian WALK / flashing CLEAR / DONT_WALK sequencer slaved to the vehicle red phase.
// Define PED_AUTO_RECALL_EN to start WALK on every vehicle red rising edge.
module ped_signal_ctrl
    import ped_pkg::*;
#(
    parameter int WALK_TIME  = WALK_TIME_DEF,
    parameter int CLEAR_TIME = CLEAR_TIME_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             veh_red,
    input  logic             veh_yellow,
    input  logic             veh_green,
    input  logic             ped_btn,
    output logic             walk,
    output logic             dont_walk,
    output logic [CNT_W-1:0] countdown,
    output logic             req_pending,
    output logic             abort
);
`ifdef PED_AUTO_RECALL_EN
    localparam logic AUTO_RECALL = 1'b1;
`else
    localparam logic AUTO_RECALL = 1'b0;
`endif
    ped_state_t       r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic r_flash, w_flash_d, r_pend, w_pend_d, r_red_q, r_abort, w_abort_d;
    logic r_walk, w_walk_d, r_dw, w_dw_d, w_rise, w_red_rise, w_unsafe, w_unused;

    ped_btn_sync u_btn (.clk(clk), .rst_n(rst_n), .async_in(ped_btn), .rise_pulse(w_rise));

    assign w_red_rise = veh_red & ~r_red_q;
    assign w_unsafe   = ~veh_red | veh_green;
    assign w_unused   = veh_yellow;

    // r_red_q resets high so a red already lit at reset release is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DONT_WALK;
            r_cnt   <= '0;
            r_flash <= 1'b0;
            r_pend  <= 1'b0;
            r_red_q <= 1'b1;
            r_abort <= 1'b0;
            r_walk  <= 1'b0;
            r_dw    <= 1'b1;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_flash <= w_flash_d;
            r_pend  <= w_pend_d;
            r_red_q <= veh_red;
            r_abort <= w_abort_d;
            r_walk  <= w_walk_d;
            r_dw    <= w_dw_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_flash_d = r_flash;
        w_pend_d  = r_pend;
        w_abort_d = 1'b0;
        case (r_state)
            DONT_WALK: begin
                if (w_red_rise && (r_pend || AUTO_RECALL)) begin
                    w_state_d = WALK;
                    w_cnt_d   = CNT_W'(WALK_TIME);
                    w_pend_d  = 1'b0;
                end else if (w_rise) w_pend_d = 1'b1;
            end
            WALK, CLEAR: begin
                if (r_state == CLEAR && w_rise) w_pend_d = 1'b1;
                if (w_unsafe) begin
                    w_state_d = DONT_WALK;
                    w_cnt_d   = '0;
                    w_flash_d = 1'b0;
                    w_abort_d = 1'b1;
                end else if (tick) begin
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_d = (r_state == WALK) ? CLEAR : DONT_WALK;
                        w_cnt_d   = (r_state == WALK) ? CNT_W'(CLEAR_TIME) : '0;
                        w_flash_d = (r_state == WALK);
                    end else begin
                        w_cnt_d   = r_cnt - CNT_W'(1);
                        w_flash_d = r_flash ^ (r_state == CLEAR);
                    end
                end
            end
            default: w_state_d = DONT_WALK;
        endcase
    end

    always_comb begin
        w_walk_d = (w_state_d == WALK);
        w_dw_d   = (w_state_d == DONT_WALK) | ((w_state_d == CLEAR) & w_flash_d);
    end

    assign walk        = r_walk;
    assign dont_walk   = r_dw;
    assign countdown   = r_cnt;
    assign req_pending = r_pend;
    assign abort       = r_abort;
endmodule

// File: tb/tb_ped_signal_ctrl.sv
// tb_ped_signal_ctrl: scoreboard bench; a spec-level model pushes expected outputs per cycle, compared after each edge
module tb_ped_signal_ctrl;
    localparam int WT = 7;
    localparam int CT = 5;
    localparam int CW = 6;
`ifdef PED_AUTO_RECALL_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    typedef struct packed {
        logic          w;
        logic          dw;
        logic [CW-1:0] c;
        logic          p;
        logic          a;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
    logic veh_red = 1'b1, veh_yellow = 1'b0, veh_green = 1'b0, ped_btn = 1'b0;
    logic walk, dont_walk, req_pending, abort;
    logic [CW-1:0] countdown;

    ped_signal_ctrl #(.WALK_TIME(WT), .CLEAR_TIME(CT), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .veh_red(veh_red), .veh_yellow(veh_yellow),
        .veh_green(veh_green), .ped_btn(ped_btn), .walk(walk), .dont_walk(dont_walk),
        .countdown(countdown), .req_pending(req_pending), .abort(abort)
    );

    always #5 clk = ~clk;

    int   errors = 0, checks = 0, cyc_n = 0, walk_entries = 0;
    exp_t sb[$];
    // model: 0 = DONT_WALK, 1 = WALK, 2 = CLEAR
    int   m_st = 0;
    int   m_cnt = 0;
    logic m_flash = 0, m_pend = 0, m_redq = 1, m_b1 = 0, m_b2 = 0, m_b3 = 0, prev_walk = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc_n);
        end
    endtask

    task automatic cyc(input logic red, input logic grn, input logic btn);
        logic rise, redr, abt;
        exp_t e, g;
        @(negedge clk);
        tick = (cyc_n % 10 == 9);
        veh_red = red;
        veh_green = grn;
        veh_yellow = ~red & ~grn;
        ped_btn = btn;
        rise = m_b2 & ~m_b3;
        redr = red & ~m_redq;
        abt = 0;
        if (m_st == 0) begin
            if (redr && (m_pend || AUTO)) begin
                m_st = 1; m_cnt = WT; m_pend = 0;
            end else if (rise) m_pend = 1;
        end else begin
            if (m_st == 2 && rise) m_pend = 1;
            if (!red || grn) begin
                m_st = 0; m_cnt = 0; m_flash = 0; abt = 1;
            end else if (tick) begin
                if (m_cnt == 1 && m_st == 1) begin
                    m_st = 2; m_cnt = CT; m_flash = 1;
                end else if (m_cnt == 1) begin
                    m_st = 0; m_cnt = 0; m_flash = 0;
                end else begin
                    m_cnt--;
                    if (m_st == 2) m_flash = ~m_flash;
                end
            end
        end
        m_b3 = m_b2; m_b2 = m_b1; m_b1 = btn; m_redq = red;
        e.w = (m_st == 1);
        e.dw = (m_st == 0) || (m_st == 2 && m_flash);
        e.c = CW'(m_cnt);
        e.p = m_pend;
        e.a = abt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check("sb_walk", walk, g.w);
        check("sb_dont_walk", dont_walk, g.dw);
        check("sb_countdown", countdown, g.c);
        check("sb_req_pending", req_pending, g.p);
        check("sb_abort", abort, g.a);
        if (walk && dont_walk) check("lamp_exclusive", 1, 0);
        if (walk && !prev_walk) walk_entries++;
        prev_walk = walk;
        cyc_n++;
    endtask

    task automatic run(input int n, input logic red, input logic grn, input logic btn);
        for (int i = 0; i < n; i++) cyc(red, grn, btn);
    endtask

    task automatic wait_st(input string tag, input int st, input logic red, input logic btn);
        int k = 0;
        while (m_st != st && k < 200) begin
            cyc(red, 1'b0, btn);
            k++;
        end
        check(tag, m_st == st, 1);
    endtask

    task automatic press_in_green();
        run(20, 1'b0, 1'b1, 1'b0);
        run(2, 1'b0, 1'b1, 1'b1);
        run(5, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int k;
        repeat (2) @(posedge clk);
        #1;
        check("rst_walk", walk, 0);
        check("rst_dont_walk", dont_walk, 1);
        check("rst_countdown", countdown, 0);
        check("rst_req_pending", req_pending, 0);
        check("rst_abort", abort, 0);
        @(negedge clk);
        rst_n = 1'b1;
        // 1: red already lit at reset release
        run(15, 1'b1, 1'b0, 1'b0);
        check("t1_no_walk", walk_entries, 0);
        check("t1_dont_walk", dont_walk, 1);
        // 2: button in green, then red phase
        run(20, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        check("t2_not_yet", req_pending, 0);
        cyc(1'b0, 1'b1, 1'b0);
        check("t2_pending", req_pending, 1);
        run(5, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("t2_walk_entry", walk, 1);
        check("t2_load", countdown, WT);
        check("t2_pend_clr", req_pending, 0);
        wait_st("t2_reach_clear", 2, 1'b1, 1'b0);
        check("t2_clear_load", countdown, CT);
        check("t2_clear_dw", dont_walk, 1);
        wait_st("t2_reach_done", 0, 1'b1, 1'b0);
        check("t2_done_cnt", countdown, 0);
        run(10, 1'b1, 1'b0, 1'b0);
        // 3: held button gives a single request
        run(10, 1'b0, 1'b1, 1'b0);
        walk_entries = 0;
        run(200, 1'b0, 1'b1, 1'b1);
        run(5, 1'b0, 1'b1, 1'b0);
        run(150, 1'b1, 1'b0, 1'b0);
        check("t3_one_walk", walk_entries, 1);
        run(30, 1'b0, 1'b1, 1'b0);
        run(150, 1'b1, 1'b0, 1'b0);
        check("t3_no_second", walk_entries, AUTO ? 2 : 1);
        // 4: red drops mid-WALK
        press_in_green();
        k = 0;
        while (!(m_st == 1 && m_cnt == 4) && k < 200) begin
            cyc(1'b1, 1'b0, 1'b0);
            k++;
        end
        check("t4_reach_cnt4", countdown, 4);
        cyc(1'b0, 1'b0, 1'b0);
        check("t4_abort", abort, 1);
        check("t4_walk_off", walk, 0);
        check("t4_cnt_zero", countdown, 0);
        check("t4_dont_walk", dont_walk, 1);
        cyc(1'b0, 1'b1, 1'b0);
        check("t4_abort_pulse", abort, 0);
        // 5: press during CLEAR is kept, press during WALK is dropped
        press_in_green();
        wait_st("t5_reach_clear", 2, 1'b1, 1'b0);
        run(2, 1'b1, 1'b0, 1'b1);
        wait_st("t5_clear_done", 0, 1'b1, 1'b0);
        check("t5_pend_kept", req_pending, 1);
        run(20, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("t5_walk_again", walk, 1);
        run(2, 1'b1, 1'b0, 1'b1);
        run(5, 1'b1, 1'b0, 1'b0);
        check("t5_walk_press", req_pending, 0);
        wait_st("t5_done", 0, 1'b1, 1'b0);
        check("t5_pend_zero", req_pending, 0);
        // 6: two red edges without any press
        walk_entries = 0;
        run(20, 1'b0, 1'b1, 1'b0);
        run(150, 1'b1, 1'b0, 1'b0);
        run(20, 1'b0, 1'b1, 1'b0);
        run(150, 1'b1, 1'b0, 1'b0);
        check("t6_recall", walk_entries, AUTO ? 2 : 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
